// File: rtl/hqm_aw_rx_sync_pkg.sv
// Shared status-word layout for the HQM rx/tx sync buffers.
package hqm_aw_rx_sync_pkg;

    localparam int ST_W        = 7;
    localparam int ST_OCC_LSB  = 0;
    localparam int ST_OCC_MSB  = 3;
    localparam int ST_FULL     = 4;
    localparam int ST_EMPTY    = 5;
    localparam int ST_ERR      = 6;

endpackage

// File: rtl/hqm_aw_rx_sync.sv
// Receive-side sync buffer on the gated unit clock.
// Circular store, wake request, occupancy/idle/error status.
module hqm_aw_rx_sync
    import hqm_aw_rx_sync_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 2,
    parameter int RESET_DATAPATH = 1
) (
    input  logic             hqm_gated_clk,
    input  logic             hqm_gated_rst,
    input  logic             enable,
    input  logic             rst_prep,
    output logic             wake,
    output logic             idle,
    output logic [ST_W-1:0]  status,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
    localparam logic [3:0]    C_FULL = 4'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [3:0]       r_cnt;
    logic             r_stall;
    logic             r_err;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == P_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_empty   = (r_cnt == 4'd0);
    assign w_full    = (r_cnt == C_FULL);
    assign in_ready  = ~w_full & ~rst_prep;
    assign out_valid = ~w_empty & enable & ~rst_prep;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign out_data  = r_mem[r_rp];

    assign wake = ~w_empty | in_valid;
    assign idle = ~rst_prep & w_empty & ~in_valid;

    always_comb begin
        status = '0;
        status[ST_OCC_MSB:ST_OCC_LSB] = r_cnt;
        status[ST_FULL]  = w_full;
        status[ST_EMPTY] = w_empty;
        status[ST_ERR]   = r_err;
    end

    always_ff @(posedge hqm_gated_clk) begin
        if (hqm_gated_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_stall <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) r_wp <= f_inc(r_wp);
            if (w_pop)  r_rp <= f_inc(r_rp);
            r_cnt   <= r_cnt + {3'b0, w_push} - {3'b0, w_pop};
            r_stall <= in_valid & ~in_ready;
            // An offer withdrawn after being refused breaks the handshake.
            if (r_stall & ~in_valid) r_err <= 1'b1;
        end
    end

    always_ff @(posedge hqm_gated_clk) begin
        if (hqm_gated_rst && (RESET_DATAPATH != 0)) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !hqm_gated_rst) begin
            r_mem[r_wp] <= in_data;
        end
    end

endmodule

// File: tb/tb_hqm_aw_rx_sync.sv
// Directed self-checking bench for hqm_aw_rx_sync (DEPTH=3).
module tb_hqm_aw_rx_sync;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        rst_prep;
    logic        wake;
    logic        idle;
    logic [6:0]  status;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_chk;
    int n_bad;

    hqm_aw_rx_sync #(.WIDTH(32), .DEPTH(3), .RESET_DATAPATH(1)) dut (
        .hqm_gated_clk (clk),
        .hqm_gated_rst (rst),
        .enable        (enable),
        .rst_prep      (rst_prep),
        .wake          (wake),
        .idle          (idle),
        .status        (status),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        enable    = 1'b1;
        rst_prep  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_status", 32'(status), 32'h20);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_wake", 32'(wake), 32'd0);

        // single push / pop
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0001;
        #1;
        chk("offer_wake", 32'(wake), 32'd1);
        chk("offer_idle", 32'(idle), 32'd0);
        step();
        in_valid = 1'b0;
        #1;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", out_data, 32'hA5A5_0001);
        chk("t1_count", 32'(status[3:0]), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("t1_status", 32'(status), 32'h20);
        chk("t1_idle", 32'(idle), 32'd1);

        // fill to full, hold fourth offer, wrap
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            step();
        end
        in_data = 32'h103;
        #1;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_flag", 32'(status[4]), 32'd1);
        chk("full_count", 32'(status[3:0]), 32'd3);
        step();
        chk("held_count", 32'(status[3:0]), 32'd3);
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        chk("pop_head", out_data, 32'h100);
        step();
        out_ready = 1'b0;
        #1;
        chk("after_pop_count", 32'(status[3:0]), 32'd2);
        chk("after_pop_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("fourth_count", 32'(status[3:0]), 32'd3);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("wrap_order", out_data, 32'h100 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        #1;
        chk("wrap_empty", 32'(status), 32'h20);

        // streaming push+pop
        in_valid = 1'b1;
        in_data  = 32'h200;
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_data = 32'h200 + 32'(i);
            #1;
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", out_data, 32'h200 + 32'(i - 1));
            chk("stream_count", 32'(status[3:0]), 32'd1);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("stream_last", out_data, 32'h214);
        step();
        out_ready = 1'b0;
        #1;
        chk("stream_empty", 32'(status), 32'h20);

        // enable low holds output, still accepts
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h300 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("dis_out_valid", 32'(out_valid), 32'd0);
        chk("dis_wake", 32'(wake), 32'd1);
        chk("dis_idle", 32'(idle), 32'd0);
        chk("dis_count", 32'(status[3:0]), 32'd2);
        enable    = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("en_data0", out_data, 32'h300);
        step();
        chk("en_data1", out_data, 32'h301);
        step();
        out_ready = 1'b0;
        #1;
        chk("en_empty", 32'(status), 32'h20);

        // rst_prep blocks both sides
        in_valid = 1'b1;
        in_data  = 32'h400;
        step();
        rst_prep  = 1'b1;
        in_data   = 32'h401;
        out_ready = 1'b1;
        #1;
        chk("prep_in_ready", 32'(in_ready), 32'd0);
        chk("prep_out_valid", 32'(out_valid), 32'd0);
        chk("prep_idle", 32'(idle), 32'd0);
        chk("prep_wake", 32'(wake), 32'd1);
        step();
        chk("prep_count", 32'(status[3:0]), 32'd1);
        rst_prep  = 1'b0;
        out_ready = 1'b0;
        step();
        chk("post_prep_count", 32'(status[3:0]), 32'd2);
        chk("no_err_yet", 32'(status[6]), 32'd0);

        // protocol error, then reset with 2 entries
        in_data = 32'h402;
        step();
        chk("err_full", 32'(status[4]), 32'd1);
        in_data = 32'h403;
        step();
        in_valid = 1'b0;
        step();
        chk("err_set", 32'(status[6]), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("err_sticky", 32'(status[6]), 32'd1);
        chk("err_count", 32'(status[3:0]), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst2_count", 32'(status[3:0]), 32'd0);
        chk("rst2_out_valid", 32'(out_valid), 32'd0);
        chk("rst2_status", 32'(status), 32'h20);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/hqm_aw_rx_sync.md
# hqm_AW_rx_sync

Receive-side synchronizer buffer at the input boundary of a clock-gated HQM unit; counterpart of the unit's transmit-side sync buffer. Accepts a valid/ready stream on the gated clock, stores up to DEPTH entries, raises a wake request whenever it holds or is offered data, and presents entries to the unit core only while the core is enabled. It reports occupancy, idle and protocol-error status in the same 7-bit status format as the transmit side, and honours rst_prep for quiescing before reset.

## Interface
- WIDTH, 32, payload width in bits.
- DEPTH, 2, number of buffer entries; legal range 2..8, not required to be a power of two.
- RESET_DATAPATH, 1, 1 = storage cleared on reset; 0 = storage not reset.
- hqm_gated_clk  in  1  unit clock; the only clock.
- hqm_gated_rst  in  1  reset; synchronous, active-high.
- enable  in  1  core enabled; gates out_valid.
- rst_prep  in  1  reset preparation; blocks both handshakes and forces idle low.
- wake  out  1  clock/power wake request to the unit's clock control.
- idle  out  1  buffer empty, no offer pending, not in rst_prep.
- status  out  7  [3:0] occupancy, [4] full, [5] empty, [6] sticky protocol error.
- in_valid  in  1  upstream offer.
- in_ready  out  1  buffer can accept.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  entry available to core.
- out_ready  in  1  core accepts.
- out_data  out  WIDTH  head entry payload.

## Operation
- Circular buffer: write pointer, read pointer (each $clog2(DEPTH) bits), occupancy count (4 bits, 0..DEPTH). Pointers wrap from DEPTH-1 to 0.
- push = in_valid & in_ready. in_ready = ~full & ~rst_prep.
- pop = out_valid & out_ready. out_valid = ~empty & enable & ~rst_prep.
- out_data = storage[read pointer], registered storage, no combinational bypass from in_data.
- count_next = count + push - pop. Push and pop in the same cycle leave count unchanged; both pointers advance.
- Full: in_ready low, even if a pop occurs that cycle. No push-through when full.
- Empty: out_valid low; a push makes the entry visible the following cycle.
- wake = ~empty | in_valid. Combinational; not gated by enable or rst_prep.
- idle = ~rst_prep & empty & ~in_valid.
- Protocol error (status[6]): set when the previous cycle had in_valid=1 and in_ready=0, and the current cycle has in_valid=0. Data stability is not checked. The bit is sticky until reset.
- rst_prep: contents, pointers and count held; no push and no pop; wake still reflects state.
- enable low: contents held; pushes still accepted.

## Timing
- Reset (hqm_gated_rst=1 at a clock edge): count=0, pointers=0, sticky error=0. Storage is 0 when RESET_DATAPATH=1.
- Outputs after reset: in_ready=1 (if rst_prep=0), out_valid=0, status=7'b0100000, idle=~in_valid & ~rst_prep, wake=in_valid.
- Latency: push at edge N gives out_valid=1 in cycle N+1 (1-cycle minimum), provided enable=1 and rst_prep=0.
- Throughput: one push and one pop per cycle, sustained while 0 < count < DEPTH.
- Reset asserted mid-operation discards all entries at that edge; no partial state is retained.
- All state updates on the rising edge of hqm_gated_clk only.

## Structure
- hqm_AW_pkg: status bit index constants (occupancy LSB/MSB, full, empty, error) shared with the transmit-side buffer.
- Flat module; no sub-module. Storage is a register array inside the block; the controller is roughly 150–250 lines.

## Test plan
- Reset, then push 0xA5A5_0001 with enable=1 → out_valid=1 next cycle, out_data=0xA5A5_0001, status[3:0]=1; pop → status=7'b0100000, idle=1.
- DEPTH=3: push 3 entries with out_ready=0 → in_ready=0, status[4]=1, count=3. A fourth offer is held. Pop one → the fourth is accepted the next cycle and the FIFO order is preserved across the wrap.
- Continuous push and pop for 20 cycles → count stays at 1, all 20 values arrive in order, no bubbles.
- enable=0 with 2 entries stored → out_valid=0, wake=1, idle=0. Raise enable → both entries drain in order.
- rst_prep=1 with 1 entry and in_valid=1 → in_ready=0, out_valid=0, idle=0, count held at 1.
- Drop in_valid while stalled on full → status[6]=1 and stays 1 until hqm_gated_rst. Assert reset with 2 entries stored → count=0 and out_valid=0 the next cycle.
